// File: rtl/b_fad_pkg.sv
// Shared widths and the combined carry/sum type for the registered 4-bit adder.
package b_fad_pkg;

    localparam int unsigned WIDTH_DEFAULT = 4;

    typedef logic [WIDTH_DEFAULT:0] sum_t;

endpackage

// File: rtl/b_fad_full_adder_bit.sv
// One-bit combinational full adder cell for the ripple chain.
module full_adder_bit (
    input  logic a,
    input  logic x,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ x ^ ci;
    assign co = (a & x) | (a & ci) | (x & ci);

endmodule

// File: rtl/b_fad.sv
// Registered ripple-carry adder: {z, y} = a + x + c, presented one clock after in_valid.
module b_fad
    import b_fad_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] x,
    input  logic             c,
    output logic             out_valid,
    output logic [WIDTH-1:0] y,
    output logic             z
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    assign carry[0] = c;

    // Carry ripples from bit 0 upward; the top carry becomes z.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_bit u_fa (
            .a  (a[i]),
            .x  (x[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            y         <= '0;
            z         <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                y <= sum;
                z <= carry[WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_b_fad.sv
// Self-checking bench for b_fad: directed vectors, hold/reset behaviour, exhaustive and random adds.
module tb_b_fad;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] x;
    logic         c;
    logic         out_valid;
    logic [W-1:0] y;
    logic         z;

    int checks;
    int failures;

    b_fad #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .x         (x),
        .c         (c),
        .out_valid (out_valid),
        .y         (y),
        .z         (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: integer add, then split into carry-out and sum.
    function automatic logic [W:0] ref_add(input int unsigned ai, input int unsigned xi,
                                           input int unsigned ci);
        int unsigned t;
        t = ai + xi + ci;
        return (W+1)'(t);
    endfunction

    task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Apply one valid operation across an edge and check the registered result after it.
    task automatic do_add(input string tag, input int unsigned ai, input int unsigned xi,
                          input int unsigned ci);
        logic [W:0] exp;
        exp      = ref_add(ai, xi, ci);
        in_valid = 1'b1;
        a        = W'(ai);
        x        = W'(xi);
        c        = 1'(ci);
        @(posedge clk);
        #1;
        chk({tag, " sum"}, {z, y}, exp);
        chk({tag, " valid"}, {{W{1'b0}}, out_valid}, (W+1)'(1));
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] x;
        logic         c;
        logic [W-1:0] y;
        logic         z;
    } vec_t;

    vec_t vecs [$];
    logic [W:0] held;
    logic [W:0] exp_q [$];

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        x        = '0;
        c        = 1'b0;
        #12;
        chk("reset_state", {z, y}, '0);
        chk("reset_valid", {{W{1'b0}}, out_valid}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Hand-computed vectors: carry-in toggling, more vectors, extremes.
        vecs.push_back('{4'b1010, 4'b1111, 1'b0, 4'b1001, 1'b1});
        vecs.push_back('{4'b1010, 4'b1111, 1'b1, 4'b1010, 1'b1});
        vecs.push_back('{4'b0010, 4'b1100, 1'b1, 4'b1111, 1'b0});
        vecs.push_back('{4'b0010, 4'b1100, 1'b0, 4'b1110, 1'b0});
        vecs.push_back('{4'b1010, 4'b0001, 1'b0, 4'b1011, 1'b0});
        vecs.push_back('{4'b1010, 4'b0001, 1'b1, 4'b1100, 1'b0});
        vecs.push_back('{4'b1010, 4'b0011, 1'b1, 4'b1110, 1'b0});
        vecs.push_back('{4'b1010, 4'b0011, 1'b0, 4'b1101, 1'b0});
        vecs.push_back('{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1});
        vecs.push_back('{4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1});
        vecs.push_back('{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0});
        foreach (vecs[i]) begin
            in_valid = 1'b1;
            a = vecs[i].a;
            x = vecs[i].x;
            c = vecs[i].c;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i), {z, y}, {vecs[i].z, vecs[i].y});
            chk($sformatf("vec%0d_valid", i), {{W{1'b0}}, out_valid}, (W+1)'(1));
        end

        // Hold: last result stays while inputs wander with in_valid low.
        do_add("pre_hold", 9, 5, 1);
        held = ref_add(9, 5, 1);
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b0;
            a = W'($urandom);
            x = W'($urandom);
            c = 1'($urandom);
            @(posedge clk);
            #1;
            chk($sformatf("hold%0d", i), {z, y}, held);
            chk($sformatf("hold%0d_valid", i), {{W{1'b0}}, out_valid}, '0);
        end

        // No combinational path: changing inputs mid-cycle leaves outputs alone.
        do_add("pre_comb", 3, 4, 0);
        a = 4'hf;
        x = 4'hf;
        c = 1'b1;
        #3;
        chk("no_comb_path", {z, y}, ref_add(3, 4, 0));

        // Exhaustive back-to-back adds, one result per cycle in order.
        for (int ai = 0; ai < 16; ai++)
            for (int xi = 0; xi < 16; xi++)
                for (int ci = 0; ci < 2; ci++)
                    do_add($sformatf("exh_%0d_%0d_%0d", ai, xi, ci), ai, xi, ci);

        // Random traffic with gaps; scoreboard tracks the last loaded result.
        held = {z, y};
        for (int i = 0; i < 200; i++) begin
            in_valid = 1'($urandom);
            a = W'($urandom);
            x = W'($urandom);
            c = 1'($urandom);
            if (in_valid) held = ref_add(int'(a), int'(x), int'(c));
            exp_q.push_back({{W{1'b0}}, in_valid});
            @(posedge clk);
            #1;
            chk($sformatf("rnd%0d", i), {z, y}, held);
            chk($sformatf("rnd%0d_valid", i), {{W{1'b0}}, out_valid}, exp_q.pop_front());
        end

        // Asynchronous reset mid-cycle while out_valid is high.
        do_add("pre_reset", 15, 15, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_sum", {z, y}, '0);
        chk("async_reset_valid", {{W{1'b0}}, out_valid}, '0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset_valid", {{W{1'b0}}, out_valid}, '0);
        chk("post_reset_sum", {z, y}, '0);
        do_add("post_reset_add", 7, 8, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
